fx_joypad: RTL

PC-FX joypad model: the device end of the K-port serial link that the gate-array keypad controller drives. It answers a host LATCH/CLK read sequence by shifting out a 32-bit pad word (ID nibble plus 16 button bits), and accepts a 32-bit host-to-pad write sequence into a receive register. It sits in the top level between MiSTer joystick inputs and one K-port (KP_LATCH/KP_CLK/KP_RW/KP_DOUT in, KP_DIN out).

---
 rtl/fx_joypad_if.sv | 13 +
 rtl/fx_joypad.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fx_joypad_if.sv
// K-port serial link between the host keypad controller and one joypad.
// master = host side (drives latch/clock/direction/write data),
// slave  = pad side (drives read data back to the host).
interface fx_joypad_if;
   logic KP_LATCH;
   logic KP_CLK;
   logic KP_RW;
   logic KP_DOUT;
   logic KP_DIN;

   modport master (output KP_LATCH, output KP_CLK, output KP_RW, output KP_DOUT, input KP_DIN);
   modport slave  (input KP_LATCH, input KP_CLK, input KP_RW, input KP_DOUT, output KP_DIN);
endinterface

// File: rtl/fx_joypad.sv
// PC-FX joypad model: device end of a K-port serial link.
// A latch rise with RW=0 shifts out {PAD_ID, 12'h000, BTN} LSB first on KP_DIN;
// with RW=1 the pad shifts 32 host bits from KP_DOUT into RX_DATA.
// Optional build macro FX_JOYPAD_SYNC_EN adds a 2-flop CE-gated synchronizer
// on the four K-port inputs for asynchronous external pads.
module fx_joypad #(
   parameter logic [3:0] PAD_ID = 4'hF
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        CE,
   input  logic        PRESENT,
   input  logic [15:0] BTN,
   fx_joypad_if.slave  kp,
   output logic [31:0] RX_DATA,
   output logic        RX_STB
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PIN_W  = 4;

   typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [WORD_W-1:0]   tx_sr, tx_sr_n;
   logic [WORD_W-1:0]   rx_sr, rx_sr_n;
   logic [WORD_W-1:0]   rx_data_n;
   logic                rx_stb_n;
   logic                din, din_n;

   logic [PIN_W-1:0]    pins, cur;
   logic                cur_latch, cur_clk, cur_rw, cur_dout;
   logic                hist_latch, hist_clk;
   logic                latch_rise, clk_rise;

   assign pins = {kp.KP_LATCH, kp.KP_CLK, kp.KP_RW, kp.KP_DOUT};

`ifdef FX_JOYPAD_SYNC_EN
   logic [PIN_W-1:0] sync1, sync2;

   // Two-flop synchronizer on all four pins so data stays aligned with clock
   always_ff @(posedge CLK) begin
      if (RES) begin
         sync1 <= '0;
         sync2 <= '0;
      end else if (CE) begin
         sync1 <= pins;
         sync2 <= sync1;
      end
   end

   assign cur = sync2;
`else
   assign cur = pins;
`endif

   assign cur_latch = cur[3];
   assign cur_clk   = cur[2];
   assign cur_rw    = cur[1];
   assign cur_dout  = cur[0];

   // History flop for latch/clock edge detection
   always_ff @(posedge CLK) begin
      if (RES) begin
         hist_latch <= 1'b0;
         hist_clk   <= 1'b0;
      end else if (CE) begin
         hist_latch <= cur_latch;
         hist_clk   <= cur_clk;
      end
   end

   assign latch_rise = cur_latch & ~hist_latch;
   assign clk_rise   = cur_clk & ~hist_clk;

   // State register
   always_ff @(posedge CLK) begin
      if (RES)     state <= IDLE;
      else if (CE) state <= state_n;
   end

   // Next-state, shift registers, receive word and registered read data
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      tx_sr_n   = tx_sr;
      rx_sr_n   = rx_sr;
      rx_data_n = RX_DATA;
      rx_stb_n  = 1'b0;

      if (!PRESENT) begin
         state_n = IDLE;
      end else if (latch_rise) begin
         // Latch wins over a coincident clock edge and aborts any transfer
         cnt_n = '0;
         if (!cur_rw) begin
            tx_sr_n = {PAD_ID, 12'h000, BTN};
            state_n = TX;
         end else begin
            rx_sr_n = '0;
            state_n = RX;
         end
      end else if (clk_rise && !cur_latch) begin
         case (state)
            TX: begin
               tx_sr_n = tx_sr >> 1;
               cnt_n   = cnt + CNT_W'(1);
               if (cnt_n == CNT_W'(WORD_W)) state_n = DONE;
            end
            RX: begin
               rx_sr_n = {cur_dout, rx_sr[WORD_W-1:1]};
               cnt_n   = cnt + CNT_W'(1);
               if (cnt_n == CNT_W'(WORD_W)) begin
                  rx_data_n = rx_sr_n;
                  rx_stb_n  = 1'b1;
                  state_n   = DONE;
               end
            end
            default: ;
         endcase
      end

      din_n = (state_n == TX) ? tx_sr_n[0] : 1'b0;
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (RES) begin
         cnt     <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         RX_DATA <= '0;
         RX_STB  <= 1'b0;
         din     <= 1'b0;
      end else if (CE) begin
         cnt     <= cnt_n;
         tx_sr   <= tx_sr_n;
         rx_sr   <= rx_sr_n;
         RX_DATA <= rx_data_n;
         RX_STB  <= rx_stb_n;
         din     <= din_n;
      end
   end

   assign kp.KP_DIN = din;

endmodule
